// File: rtl/fc8_irq_pkg.sv
// Shared constants and types for the FC8 interrupt controller.
package fc8_irq_pkg;

    localparam int IRQ_TIMER  = 0;
    localparam int IRQ_TEXT   = 1;
    localparam int IRQ_TILE   = 2;
    localparam int IRQ_SPRITE = 3;
    localparam int IRQ_AUDIO  = 4;

    localparam logic [1:0] SFR_ENABLE   = 2'd0;
    localparam logic [1:0] SFR_PENDING  = 2'd1;
    localparam logic [1:0] SFR_STATUS   = 2'd2;
    localparam logic [1:0] SFR_NMI_CTRL = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        SERVICE = 2'd2
    } irq_state_e;

endpackage

// File: rtl/fc8_irq_prio_enc.sv
// Lowest-index-wins priority encoder over the active request vector.
module fc8_irq_prio_enc #(
    parameter int N = 5,
    parameter int W = 3
) (
    input  logic [N-1:0] req_i,
    output logic         valid_o,
    output logic [W-1:0] idx_o
);

    always_comb begin
        valid_o = |req_i;
        idx_o   = '0;
        // Scan downward so the lowest set index is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) idx_o = W'(i);
        end
    end

endmodule

// File: rtl/fc8_interrupt_controller.sv
// Merges the maskable sources into cpu_irq_n via a one-deep service FSM and
// turns VBLANK rising edges into a latched NMI.
module fc8_interrupt_controller
    import fc8_irq_pkg::*;
#(
    parameter int NUM_SRC = 5,
    parameter int VEC_W   = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               vblank_in,
    input  logic               sfr_sel,
    input  logic [1:0]         sfr_addr,
    input  logic               sfr_we,
    input  logic [7:0]         sfr_wdata,
    output logic [7:0]         sfr_rdata,
    input  logic               irq_ack,
    input  logic               nmi_ack,
    output logic               cpu_irq_n,
    output logic               cpu_nmi_n,
    output logic [VEC_W-1:0]   irq_vector
);

    irq_state_e         state_q, state_d;
    logic [NUM_SRC-1:0] src_q, en_q, pend_q, pend_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic               vb_q, nmi_en_q, nmi_pend_q, nmi_pend_d, nmi_n_q;
    logic               irq_n_q, irq_n_d, in_service;

    logic wr;
    assign wr = sfr_sel & sfr_we;

    logic wr_en, wr_pend, wr_status, wr_nmi;
    assign wr_en     = wr && (sfr_addr == SFR_ENABLE);
    assign wr_pend   = wr && (sfr_addr == SFR_PENDING);
    assign wr_status = wr && (sfr_addr == SFR_STATUS);
    assign wr_nmi    = wr && (sfr_addr == SFR_NMI_CTRL);

    logic unused_wdata;
    assign unused_wdata = ^sfr_wdata;

    logic               win_vld;
    logic [VEC_W-1:0]   win_idx;

    fc8_irq_prio_enc #(.N(NUM_SRC), .W(VEC_W)) u_prio (
        .req_i   (pend_q & en_q),
        .valid_o (win_vld),
        .idx_o   (win_idx)
    );

    logic               ack_take;
    logic [NUM_SRC-1:0] ack_clr, w1c_mask, rise;
    assign ack_take = (state_q == ASSERT) && win_vld && irq_ack;
    assign ack_clr  = ack_take ? (NUM_SRC'(1) << win_idx) : '0;
    assign w1c_mask = wr_pend ? sfr_wdata[NUM_SRC-1:0] : '0;
    assign rise     = irq_src & ~src_q;

    // OR-ing the rise in last lets a new edge win over a same-cycle clear.
    assign pend_d     = (pend_q & ~(w1c_mask | ack_clr)) | rise;
    assign nmi_pend_d = (nmi_pend_q & ~(nmi_ack | (wr_nmi & sfr_wdata[7])))
                      | (vblank_in & ~vb_q & nmi_en_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            src_q      <= '0;
            en_q       <= '0;
            pend_q     <= '0;
            vec_q      <= '0;
            irq_n_q    <= 1'b1;
            vb_q       <= 1'b0;
            nmi_en_q   <= 1'b1;
            nmi_pend_q <= 1'b0;
            nmi_n_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            src_q      <= irq_src;
            pend_q     <= pend_d;
            vec_q      <= vec_d;
            irq_n_q    <= irq_n_d;
            vb_q       <= vblank_in;
            nmi_pend_q <= nmi_pend_d;
            nmi_n_q    <= ~nmi_pend_q;
            if (wr_en)  en_q     <= sfr_wdata[NUM_SRC-1:0];
            if (wr_nmi) nmi_en_q <= sfr_wdata[0];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_vld) state_d = ASSERT;
            ASSERT: begin
                if (!win_vld)     state_d = IDLE;
                else if (irq_ack) state_d = SERVICE;
            end
            SERVICE: if (wr_status) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // irq_n drops only on the second cycle in ASSERT, giving the two-cycle
    // edge-to-line latency and releasing on the edge that leaves ASSERT.
    always_comb begin
        irq_n_d    = !((state_q == ASSERT) && (state_d == ASSERT));
        in_service = (state_q == SERVICE);
        vec_d      = ack_take ? win_idx : vec_q;
    end

    always_comb begin
        sfr_rdata = '0;
        case (sfr_addr)
            SFR_ENABLE:  sfr_rdata[NUM_SRC-1:0] = en_q;
            SFR_PENDING: sfr_rdata[NUM_SRC-1:0] = pend_q;
            SFR_STATUS: begin
                sfr_rdata[VEC_W-1:0] = vec_q;
                sfr_rdata[7]         = in_service;
            end
            default: begin
                sfr_rdata[0] = nmi_en_q;
                sfr_rdata[7] = nmi_pend_q;
            end
        endcase
    end

    assign cpu_irq_n  = irq_n_q;
    assign cpu_nmi_n  = nmi_n_q;
    assign irq_vector = vec_q;

endmodule

// File: tb/tb_fc8_interrupt_controller.sv
// Scoreboarded bench: directed scenarios plus randomized request/enable mixes.
module tb_fc8_interrupt_controller;
    import fc8_irq_pkg::*;

    localparam int NS = 5;
    localparam int VW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NS-1:0] irq_src = '0;
    logic          vblank_in = 1'b0;
    logic          sfr_sel = 1'b0, sfr_we = 1'b0;
    logic [1:0]    sfr_addr = '0;
    logic [7:0]    sfr_wdata = '0;
    logic [7:0]    sfr_rdata;
    logic          irq_ack = 1'b0, nmi_ack = 1'b0;
    logic          cpu_irq_n, cpu_nmi_n;
    logic [VW-1:0] irq_vector;

    always #5 clk = ~clk;

    fc8_interrupt_controller #(.NUM_SRC(NS), .VEC_W(VW)) dut (
        .clk(clk), .rst_n(rst_n), .irq_src(irq_src), .vblank_in(vblank_in),
        .sfr_sel(sfr_sel), .sfr_addr(sfr_addr), .sfr_we(sfr_we),
        .sfr_wdata(sfr_wdata), .sfr_rdata(sfr_rdata), .irq_ack(irq_ack),
        .nmi_ack(nmi_ack), .cpu_irq_n(cpu_irq_n), .cpu_nmi_n(cpu_nmi_n),
        .irq_vector(irq_vector)
    );

    int            checks = 0, errors = 0;
    logic [NS-1:0] m_pend = '0, m_en = '0, m_prev = '0;
    int            m_vec = 0;
    int            exp_q[$];
    logic          ack_taken = 1'b0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic int lowest(logic [NS-1:0] v);
        for (int i = 0; i < NS; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Reference: pending collects every 0->1 of the driven sources.
    task automatic tick();
        @(posedge clk);
        m_pend = m_pend | (irq_src & ~m_prev);
        m_prev = irq_src;
        #1;
    endtask

    task automatic sfr_wr(logic [1:0] a, logic [7:0] d);
        sfr_sel = 1'b1; sfr_we = 1'b1; sfr_addr = a; sfr_wdata = d;
        if (a == SFR_PENDING) m_pend = m_pend & ~d[NS-1:0];
        if (a == SFR_ENABLE)  m_en = d[NS-1:0];
        tick();
        sfr_sel = 1'b0; sfr_we = 1'b0;
    endtask

    task automatic sfr_rd(string n, logic [1:0] a, logic [7:0] exp);
        sfr_sel = 1'b1; sfr_we = 1'b0; sfr_addr = a;
        #1;
        chk(n, sfr_rdata, exp);
        sfr_sel = 1'b0;
    endtask

    task automatic do_ack();
        int w;
        w = lowest(m_pend & m_en);
        if (w < 0) w = 0;
        exp_q.push_back(w);
        m_pend[w] = 1'b0;
        m_vec = w;
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    task automatic wait_irq(string n, int bound);
        int k = 0;
        while (cpu_irq_n !== 1'b0 && k < bound) begin
            tick();
            k++;
        end
        chk(n, cpu_irq_n, 0);
    endtask

    // Monitor: every accepted IRQ acknowledge must present the scoreboard's vector.
    always @(posedge clk) ack_taken <= irq_ack && (cpu_irq_n === 1'b0);

    always @(negedge clk) begin
        if (ack_taken) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL vector_unexpected got %0d want none", irq_vector);
            end else begin
                chk("irq_vector", irq_vector, exp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [NS-1:0] r, e;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        chk("rst_irq_n", cpu_irq_n, 1);
        chk("rst_nmi_n", cpu_nmi_n, 1);
        sfr_rd("rst_enable", SFR_ENABLE, 8'h00);
        sfr_rd("rst_pending", SFR_PENDING, 8'h00);
        sfr_rd("rst_status", SFR_STATUS, 8'h00);
        sfr_rd("rst_nmictrl", SFR_NMI_CTRL, 8'h01);

        // Single source, exact latency.
        sfr_wr(SFR_ENABLE, 8'h01);
        irq_src[0] = 1'b1;
        tick();
        sfr_rd("t1_pending", SFR_PENDING, 8'h01);
        chk("t1_irq_n_e0", cpu_irq_n, 1);
        irq_src[0] = 1'b0;
        tick();
        chk("t1_irq_n_e1", cpu_irq_n, 1);
        tick();
        chk("t1_irq_n_e2", cpu_irq_n, 0);
        do_ack();
        sfr_rd("t1_status", SFR_STATUS, 8'h80);
        sfr_rd("t1_pend_clr", SFR_PENDING, 8'h00);
        chk("t1_irq_n_ack", cpu_irq_n, 1);
        sfr_wr(SFR_STATUS, 8'h00);
        sfr_rd("t1_eoi", SFR_STATUS, 8'h00);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        sfr_rd("t1_stray_ack", SFR_STATUS, 8'h00);

        // Two simultaneous sources: lowest index first, then the other.
        sfr_wr(SFR_ENABLE, 8'h1F);
        irq_src = 5'b01010;
        tick();
        irq_src = '0;
        wait_irq("t2_irq_a", 4);
        do_ack();
        sfr_wr(SFR_STATUS, 8'h00);
        wait_irq("t2_irq_b", 4);
        do_ack();
        sfr_wr(SFR_STATUS, 8'h00);
        sfr_rd("t2_pending", SFR_PENDING, 8'h00);

        // Masked pending, late enable, cleared before acknowledge.
        sfr_wr(SFR_ENABLE, 8'h00);
        irq_src[4] = 1'b1;
        tick();
        irq_src = '0;
        repeat (3) tick();
        sfr_rd("t3_pending", SFR_PENDING, 8'h10);
        chk("t3_masked", cpu_irq_n, 1);
        sfr_wr(SFR_ENABLE, 8'h10);
        tick();
        tick();
        chk("t3_enabled", cpu_irq_n, 0);
        sfr_wr(SFR_PENDING, 8'h10);
        tick();
        chk("t3_withdrawn", cpu_irq_n, 1);
        sfr_rd("t3_status", SFR_STATUS, 8'h03);
        repeat (2) tick();
        chk("t3_idle", cpu_irq_n, 1);

        // NMI from VBLANK.
        vblank_in = 1'b1;
        tick();
        chk("n1_e0", cpu_nmi_n, 1);
        sfr_rd("n1_ctrl", SFR_NMI_CTRL, 8'h81);
        tick();
        chk("n1_e1", cpu_nmi_n, 0);
        repeat (3) tick();
        chk("n1_hold", cpu_nmi_n, 0);
        nmi_ack = 1'b1;
        tick();
        nmi_ack = 1'b0;
        tick();
        chk("n1_ack", cpu_nmi_n, 1);
        sfr_rd("n1_ctrl_clr", SFR_NMI_CTRL, 8'h01);
        vblank_in = 1'b0;
        tick();
        vblank_in = 1'b1;
        tick();
        vblank_in = 1'b0;
        tick();
        chk("n2_low", cpu_nmi_n, 0);
        vblank_in = 1'b1; nmi_ack = 1'b1;
        tick();
        nmi_ack = 1'b0;
        sfr_rd("n2_set_wins", SFR_NMI_CTRL, 8'h81);
        tick();
        chk("n2_still_low", cpu_nmi_n, 0);
        sfr_wr(SFR_NMI_CTRL, 8'h81);
        sfr_rd("n2_w1c", SFR_NMI_CTRL, 8'h01);
        tick();
        chk("n2_w1c_line", cpu_nmi_n, 1);
        vblank_in = 1'b0;
        sfr_wr(SFR_NMI_CTRL, 8'h00);
        vblank_in = 1'b1;
        repeat (3) tick();
        chk("n3_disabled", cpu_nmi_n, 1);
        sfr_rd("n3_ctrl", SFR_NMI_CTRL, 8'h00);
        vblank_in = 1'b0;
        sfr_wr(SFR_NMI_CTRL, 8'h01);

        // Rise coincident with write-1-to-clear keeps the bit.
        sfr_wr(SFR_ENABLE, 8'h00);
        irq_src[2] = 1'b1;
        tick();
        irq_src = '0;
        tick();
        sfr_rd("c1_pre", SFR_PENDING, 8'h04);
        irq_src[2] = 1'b1;
        sfr_wr(SFR_PENDING, 8'h04);
        irq_src = '0;
        sfr_rd("c1_set_wins", SFR_PENDING, 8'h04);

        // Asynchronous reset while asserting.
        sfr_wr(SFR_ENABLE, 8'h04);
        wait_irq("r1_assert", 4);
        rst_n = 1'b0;
        m_pend = '0; m_en = '0; m_prev = '0; m_vec = 0;
        #1;
        chk("r1_irq_n", cpu_irq_n, 1);
        sfr_rd("r1_pending", SFR_PENDING, 8'h00);
        sfr_rd("r1_enable", SFR_ENABLE, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Randomized request/enable mixes against the reference model.
        for (int it = 0; it < 30; it++) begin
            sfr_wr(SFR_PENDING, 8'hFF);
            r = NS'($urandom_range(1, 31));
            e = NS'($urandom_range(0, 31));
            irq_src = r;
            tick();
            irq_src = '0;
            tick();
            sfr_wr(SFR_ENABLE, 8'(e));
            if ((m_pend & m_en) != 0) begin
                wait_irq("rnd_irq", 6);
                do_ack();
                sfr_rd("rnd_pending", SFR_PENDING, 8'(m_pend));
                sfr_rd("rnd_status", SFR_STATUS, 8'h80 | 8'(m_vec));
                sfr_wr(SFR_STATUS, 8'h00);
            end else begin
                repeat (3) tick();
                chk("rnd_quiet", cpu_irq_n, 1);
            end
        end

        repeat (2) tick();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
